// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg
//   Shared definitions for the UART receiver slice.
//   - rx_state_t : receiver FSM states (IDLE/START/DATA/PARITY/STOP)
//   - BITLEN_*   : decode values of the 2-bit data-length field
//   - bit_count(): maps the data-length field to a bit count of 5..8
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam logic [1:0] BITLEN_5 = 2'b00;
  localparam logic [1:0] BITLEN_6 = 2'b01;
  localparam logic [1:0] BITLEN_7 = 2'b10;
  localparam logic [1:0] BITLEN_8 = 2'b11;

  function automatic logic [3:0] bit_count(input logic [1:0] bit_length);
    logic [3:0] n;
    case (bit_length)
      BITLEN_5: n = 4'd5;
      BITLEN_6: n = 4'd6;
      BITLEN_7: n = 4'd7;
      BITLEN_8: n = 4'd8;
      default:  n = 4'd8;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if
//   Configuration and result bundle of the UART receiver.
//   Config  : Rx_BitLength_i (00=5..11=8 bits), Rx_ParityEN_i, Rx_OddParity_i, Rx_Enable_i
//   Results : Rx_Data_o[7:0], RxD_Ready_o (1-cycle pulse), RxD_ParityError_o,
//             RxD_FramingError_o, Rx_operation_o, Rx_ShiftClock_o (1-cycle pulse)
//   Modports: master = receiver side (drives results), slave = consumer side.
interface uart_rx_if;

  logic [1:0] Rx_BitLength_i;
  logic       Rx_ParityEN_i;
  logic       Rx_OddParity_i;
  logic       Rx_Enable_i;
  logic [7:0] Rx_Data_o;
  logic       RxD_Ready_o;
  logic       RxD_ParityError_o;
  logic       RxD_FramingError_o;
  logic       Rx_operation_o;
  logic       Rx_ShiftClock_o;

  modport master (
    input  Rx_BitLength_i, Rx_ParityEN_i, Rx_OddParity_i, Rx_Enable_i,
    output Rx_Data_o, RxD_Ready_o, RxD_ParityError_o, RxD_FramingError_o,
           Rx_operation_o, Rx_ShiftClock_o
  );

  modport slave (
    output Rx_BitLength_i, Rx_ParityEN_i, Rx_OddParity_i, Rx_Enable_i,
    input  Rx_Data_o, RxD_Ready_o, RxD_ParityError_o, RxD_FramingError_o,
           Rx_operation_o, Rx_ShiftClock_o
  );

endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync
//   Brings the asynchronous serial line into the m_clock domain and derives
//   the start-edge strobe and the bit value used at each sample point.
//   Ports:
//     m_clock    in  system clock
//     p_reset    in  asynchronous active-high reset (line flops reset to idle = 1)
//     rxd_async  in  raw serial line
//     start_fall out 1->0 transition seen on the synchronised line
//     bit_value  out value to use when the receiver samples a bit
//   Optional feature: UART_RX_MAJORITY_VOTE_EN -> bit_value is the 2-of-3
//   majority of the last three synchronised samples, otherwise the newest one.
module uart_rx_sync (
  input  logic m_clock,
  input  logic p_reset,
  input  logic rxd_async,
  output logic start_fall,
  output logic bit_value
);

  logic meta_reg;
  logic sync_reg;
  logic hist1_reg;

  always_ff @(posedge m_clock or posedge p_reset) begin
    if (p_reset) begin
      meta_reg  <= 1'b1;
      sync_reg  <= 1'b1;
      hist1_reg <= 1'b1;
    end else begin
      meta_reg  <= rxd_async;
      sync_reg  <= meta_reg;
      hist1_reg <= sync_reg;
    end
  end

  // The edge requires the line to have been high one cycle earlier, so a
  // line held low (break) never produces a new start.
  assign start_fall = hist1_reg & ~sync_reg;

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic hist2_reg;

  always_ff @(posedge m_clock or posedge p_reset) begin
    if (p_reset) hist2_reg <= 1'b1;
    else         hist2_reg <= hist1_reg;
  end

  // Taps are mid+1 (sync), mid (hist1), mid-1 (hist2): the vote window is
  // centred one cycle earlier than the single sample, which keeps the
  // decision edge and therefore the Ready latency unchanged.
  assign bit_value = (sync_reg & hist1_reg) | (sync_reg & hist2_reg) |
                     (hist1_reg & hist2_reg);
`else
  assign bit_value = sync_reg;
`endif

endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core
//   UART receiver: 5-8 data bits, optional odd/even parity, one stop bit,
//   LSB first. Pulses RxD_Ready_o once per completed frame.
//   Parameters:
//     CLKS_PER_BIT  m_clock cycles per bit (even, >= 4)
//   Ports:
//     m_clock  in  system clock
//     p_reset  in  asynchronous active-high reset
//     RxD_i    in  serial line, idle high, asynchronous
//     rx_bus   uart_rx_if.master: configuration in, data/flags/strobes out
//   Optional feature: UART_RX_MAJORITY_VOTE_EN (see uart_rx_sync).
module uart_rx_core
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic      m_clock,
  input  logic      p_reset,
  input  logic      RxD_i,
  uart_rx_if.master rx_bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);

  logic start_fall;
  logic bit_value;

  uart_rx_sync u_sync (
    .m_clock    (m_clock),
    .p_reset    (p_reset),
    .rxd_async  (RxD_i),
    .start_fall (start_fall),
    .bit_value  (bit_value)
  );

  rx_state_t        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       bit_idx_reg, bit_idx_next;
  logic [3:0]       nbits_reg, nbits_next;
  logic             par_en_reg, par_en_next;
  logic             par_odd_reg, par_odd_next;
  logic             par_acc_reg, par_acc_next;
  logic             par_err_reg, par_err_next;
  logic [7:0]       data_sr_reg, data_sr_next;
  logic [7:0]       data_out_reg, data_out_next;
  logic             perr_out_reg, perr_out_next;
  logic             ferr_out_reg, ferr_out_next;
  logic             ready_reg, ready_next;
  logic             shift_clk_reg, shift_clk_next;

  always_ff @(posedge m_clock or posedge p_reset) begin
    if (p_reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      bit_idx_reg   <= '0;
      nbits_reg     <= 4'd8;
      par_en_reg    <= 1'b0;
      par_odd_reg   <= 1'b0;
      par_acc_reg   <= 1'b0;
      par_err_reg   <= 1'b0;
      data_sr_reg   <= '0;
      data_out_reg  <= '0;
      perr_out_reg  <= 1'b0;
      ferr_out_reg  <= 1'b0;
      ready_reg     <= 1'b0;
      shift_clk_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      bit_idx_reg   <= bit_idx_next;
      nbits_reg     <= nbits_next;
      par_en_reg    <= par_en_next;
      par_odd_reg   <= par_odd_next;
      par_acc_reg   <= par_acc_next;
      par_err_reg   <= par_err_next;
      data_sr_reg   <= data_sr_next;
      data_out_reg  <= data_out_next;
      perr_out_reg  <= perr_out_next;
      ferr_out_reg  <= ferr_out_next;
      ready_reg     <= ready_next;
      shift_clk_reg <= shift_clk_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    bit_idx_next   = bit_idx_reg;
    nbits_next     = nbits_reg;
    par_en_next    = par_en_reg;
    par_odd_next   = par_odd_reg;
    par_acc_next   = par_acc_reg;
    par_err_next   = par_err_reg;
    data_sr_next   = data_sr_reg;
    data_out_next  = data_out_reg;
    perr_out_next  = perr_out_reg;
    ferr_out_next  = ferr_out_reg;
    ready_next     = 1'b0;
    shift_clk_next = 1'b0;

    if (!rx_bus.Rx_Enable_i) begin
      // Abort silently; the last frame's results stay visible.
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start_fall) begin
            state_next   = START;
            cnt_next     = HALF_LOAD;
            bit_idx_next = '0;
            nbits_next   = bit_count(rx_bus.Rx_BitLength_i);
            par_en_next  = rx_bus.Rx_ParityEN_i;
            par_odd_next = rx_bus.Rx_OddParity_i;
            par_acc_next = 1'b0;
            par_err_next = 1'b0;
            data_sr_next = '0;
          end
        end

        START: begin
          if (cnt_reg == '0) begin
            shift_clk_next = 1'b1;
            cnt_next       = FULL_LOAD;
            // A line back high at mid-start was a glitch, not a frame.
            state_next     = bit_value ? IDLE : DATA;
          end else begin
            cnt_next = cnt_reg - 1'b1;
          end
        end

        DATA: begin
          if (cnt_reg == '0) begin
            shift_clk_next = 1'b1;
            cnt_next       = FULL_LOAD;
            // Shift in at the top; short words are right-aligned at Ready.
            data_sr_next   = {bit_value, data_sr_reg[7:1]};
            par_acc_next   = par_acc_reg ^ bit_value;
            if ({1'b0, bit_idx_reg} == (nbits_reg - 4'd1)) begin
              state_next = par_en_reg ? PARITY : STOP;
            end else begin
              bit_idx_next = bit_idx_reg + 3'd1;
            end
          end else begin
            cnt_next = cnt_reg - 1'b1;
          end
        end

        PARITY: begin
          if (cnt_reg == '0) begin
            shift_clk_next = 1'b1;
            cnt_next       = FULL_LOAD;
            // Expected parity is XOR of data, inverted for odd sense.
            par_err_next   = bit_value ^ par_acc_reg ^ par_odd_reg;
            state_next     = STOP;
          end else begin
            cnt_next = cnt_reg - 1'b1;
          end
        end

        STOP: begin
          if (cnt_reg == '0) begin
            shift_clk_next = 1'b1;
            ready_next     = 1'b1;
            data_out_next  = data_sr_reg >> (4'd8 - nbits_reg);
            perr_out_next  = par_en_reg & par_err_reg;
            ferr_out_next  = ~bit_value;
            state_next     = IDLE;
          end else begin
            cnt_next = cnt_reg - 1'b1;
          end
        end

        default: state_next = IDLE;
      endcase
    end
  end

  assign rx_bus.Rx_Data_o          = data_out_reg;
  assign rx_bus.RxD_Ready_o        = ready_reg;
  assign rx_bus.RxD_ParityError_o  = perr_out_reg;
  assign rx_bus.RxD_FramingError_o = ferr_out_reg;
  assign rx_bus.Rx_operation_o     = (state_reg != IDLE);
  assign rx_bus.Rx_ShiftClock_o    = shift_clk_reg;

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core
//   Directed bench for uart_rx_core at CLKS_PER_BIT=16: frame decode, parity,
//   framing/break, false start, short words, enable abort and reset abort.
module tb_uart_rx_core;

  localparam int CPB = 16;

  logic m_clock = 1'b0;
  logic p_reset = 1'b1;
  logic rxd     = 1'b1;

  uart_rx_if rx_if ();

  uart_rx_core #(.CLKS_PER_BIT(CPB)) dut (
    .m_clock (m_clock),
    .p_reset (p_reset),
    .RxD_i   (rxd),
    .rx_bus  (rx_if)
  );

  always #5 m_clock = ~m_clock;

  int total = 0;
  int bad   = 0;

  int edge_cnt       = 0;
  int ready_cnt      = 0;
  int ready_edge     = 0;
  int shclk_cnt      = 0;
  int shclk_at_ready = 0;
  int t0             = 0;
  bit op_seen        = 1'b0;

  always @(posedge m_clock) edge_cnt++;

  always @(negedge m_clock) begin
    if (rx_if.RxD_Ready_o === 1'b1) begin
      ready_cnt++;
      ready_edge     = edge_cnt;
      shclk_at_ready = shclk_cnt;
    end
    if (rx_if.Rx_ShiftClock_o === 1'b1) shclk_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge m_clock);
  endtask

  // Drives one frame at bit rate; t0 marks the start falling edge.
  task automatic send_frame(input logic [7:0] d, input int nb, input bit pe,
                            input bit pb, input bit sb, input bit idle_lvl);
    @(negedge m_clock);
    rxd = 1'b0;
    t0  = edge_cnt;
    wait_clk(CPB);
    for (int i = 0; i < nb; i++) begin
      rxd = d[i];
      wait_clk(CPB);
    end
    if (pe) begin
      rxd = pb;
      wait_clk(CPB);
    end
    rxd = sb;
    wait_clk(CPB);
    rxd = idle_lvl;
    wait_clk(4);
    $display("frame sent=%02h nb=%0d rx_data=%02h perr=%0d ferr=%0d readies=%0d",
             d, nb, rx_if.Rx_Data_o, rx_if.RxD_ParityError_o,
             rx_if.RxD_FramingError_o, ready_cnt);
  endtask

  task automatic set_cfg(input logic [1:0] bl, input bit pe, input bit odd);
    rx_if.Rx_BitLength_i = bl;
    rx_if.Rx_ParityEN_i  = pe;
    rx_if.Rx_OddParity_i = odd;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int rc;
    int base;
    set_cfg(2'b11, 1'b0, 1'b0);
    rx_if.Rx_Enable_i = 1'b1;
    wait_clk(3);

    check_eq("reset_data",  rx_if.Rx_Data_o, 32'h0);
    check_eq("reset_ready", rx_if.RxD_Ready_o, 32'h0);
    check_eq("reset_op",    rx_if.Rx_operation_o, 32'h0);
    check_eq("reset_errs",  {rx_if.RxD_ParityError_o, rx_if.RxD_FramingError_o}, 32'h0);
    p_reset = 1'b0;
    wait_clk(5);

    // 1: 8N1 0xA5 with latency
    rc = ready_cnt;
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("t1_ready_count", ready_cnt - rc, 32'd1);
    check_eq("t1_data", rx_if.Rx_Data_o, 32'hA5);
    check_eq("t1_errs", {rx_if.RxD_ParityError_o, rx_if.RxD_FramingError_o}, 32'h0);
    check_eq("t1_latency", ready_edge - t0, 32'd155);

    // 2: 7E, 0x55 has four ones -> even parity bit should be 0
    set_cfg(2'b10, 1'b1, 1'b0);
    send_frame(8'h55, 7, 1'b1, 1'b1, 1'b1, 1'b1);
    check_eq("t2_data", rx_if.Rx_Data_o, 32'h55);
    check_eq("t2_perr_bad", rx_if.RxD_ParityError_o, 32'h1);
    send_frame(8'h55, 7, 1'b1, 1'b0, 1'b1, 1'b1);
    check_eq("t2_perr_good", rx_if.RxD_ParityError_o, 32'h0);

    // 8O, 0xA5 has four ones -> odd parity bit should be 1
    set_cfg(2'b11, 1'b1, 1'b1);
    send_frame(8'hA5, 8, 1'b1, 1'b1, 1'b1, 1'b1);
    check_eq("odd_perr_good", rx_if.RxD_ParityError_o, 32'h0);
    send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b1, 1'b1);
    check_eq("odd_perr_bad", rx_if.RxD_ParityError_o, 32'h1);

    // 3: framing error followed by a break
    set_cfg(2'b11, 1'b0, 1'b0);
    rc = ready_cnt;
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("t3_ready_count", ready_cnt - rc, 32'd1);
    check_eq("t3_ferr", rx_if.RxD_FramingError_o, 32'h1);
    check_eq("t3_data", rx_if.Rx_Data_o, 32'h3C);
    check_eq("t3_perr_disabled", rx_if.RxD_ParityError_o, 32'h0);
    wait_clk(300);
    check_eq("t3_break_single", ready_cnt - rc, 32'd1);
    rxd = 1'b1;
    wait_clk(20);

    // 4: false start (5 low cycles)
    rc = ready_cnt;
    @(negedge m_clock);
    rxd = 1'b0;
    wait_clk(5);
    check_eq("t4_op_high", rx_if.Rx_operation_o, 32'h1);
    rxd = 1'b1;
    wait_clk(9);
    check_eq("t4_op_low", rx_if.Rx_operation_o, 32'h0);
    wait_clk(40);
    check_eq("t4_no_ready", ready_cnt - rc, 32'd0);
    $display("false start: readies=%0d", ready_cnt);

    // 5: 5-bit word, shift-clock pulses before Ready
    set_cfg(2'b00, 1'b0, 1'b0);
    base = shclk_cnt;
    send_frame(8'h1F, 5, 1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("t5_data", rx_if.Rx_Data_o, 32'h1F);
    check_eq("t5_shclk", shclk_at_ready - base, 32'd6);
    check_eq("t5_shclk_total", shclk_cnt - base, 32'd7);

    // Enable dropped mid-frame: abort, results retained
    set_cfg(2'b11, 1'b0, 1'b0);
    rc = ready_cnt;
    @(negedge m_clock);
    rxd = 1'b0;
    wait_clk(CPB);
    rxd = 1'b1;
    wait_clk(CPB);
    rx_if.Rx_Enable_i = 1'b0;
    wait_clk(1);
    check_eq("en_op_low", rx_if.Rx_operation_o, 32'h0);
    wait_clk(200);
    check_eq("en_no_ready", ready_cnt - rc, 32'd0);
    check_eq("en_data_kept", rx_if.Rx_Data_o, 32'h1F);
    rx_if.Rx_Enable_i = 1'b1;
    wait_clk(5);
    $display("enable abort: readies=%0d data=%02h", ready_cnt, rx_if.Rx_Data_o);

    // 6: reset during DATA
    rc = ready_cnt;
    @(negedge m_clock);
    rxd = 1'b0;
    wait_clk(CPB);
    rxd = 1'b1;
    wait_clk(CPB);
    rxd = 1'b0;
    wait_clk(CPB);
    p_reset = 1'b1;
    rxd = 1'b1;
    wait_clk(1);
    check_eq("t6_rst_data", rx_if.Rx_Data_o, 32'h0);
    check_eq("t6_rst_op", rx_if.Rx_operation_o, 32'h0);
    check_eq("t6_rst_flags", {rx_if.RxD_Ready_o, rx_if.Rx_ShiftClock_o,
                              rx_if.RxD_ParityError_o, rx_if.RxD_FramingError_o}, 32'h0);
    wait_clk(3);
    p_reset = 1'b0;
    wait_clk(200);
    check_eq("t6_no_ready", ready_cnt - rc, 32'd0);
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("t6_ready_count", ready_cnt - rc, 32'd1);
    check_eq("t6_data", rx_if.Rx_Data_o, 32'h81);
    check_eq("t6_latency", ready_edge - t0, 32'd155);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
